// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - single-frame stream capture buffer with random-access read port (optional CAPTURE_TIMEOUT_EN)
module axis_frame_capture #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 784,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    output logic              armAck_o,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] word_count_o,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   count_inc;
    logic                overflow_q, overflow_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_data_q;
    logic                busy;
    logic                xfer;
    logic                arm_accept;
    logic                timeout_hit;

    // Ready is a pure function of state so upstream never sees a combinational loop.
    assign busy       = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    assign xfer       = busy && s_valid_i;
    assign arm_accept = arm_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign count_inc  = count_q + ADDR_W'(1);

`ifdef CAPTURE_TIMEOUT_EN
    localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;

    // The limit-th consecutive idle cycle aborts the capture.
    assign timeout_hit = busy && !s_valid_i && (idle_q == IDLE_LAST);
    assign timeout_o   = timeout_q;

    // Idle counter: cleared by arm or any transfer, counts empty busy cycles.
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (arm_accept) begin
            idle_d    = '0;
            timeout_d = 1'b0;
        end else if (xfer) begin
            idle_d = '0;
        end else if (busy) begin
            if (timeout_hit) begin
                idle_d    = '0;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    // Idle counter and sticky timeout flag registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Next-state logic: arm restarts, transfers advance count, last or limit ends the frame.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ack_d      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_accept) begin
                    state_d    = S_CAPTURE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    ack_d      = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (s_valid_i) begin
                    count_d = count_inc;
                    if (s_last_i) begin
                        state_d = S_DONE;
                    end else if (count_inc == DEPTH_A) begin
                        state_d    = S_DRAIN;
                        overflow_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (s_valid_i && s_last_i) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; reset drops any partial frame.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ack_q      <= ack_d;
        end
    end

    // Buffer write port; only CAPTURE stores, DRAIN discards.
    always_ff @(posedge clk_i) begin
        if ((state_q == S_CAPTURE) && s_valid_i) begin
            mem_q[count_q] <= s_data_i;
        end
    end

    // Registered read port; out-of-range addresses keep the previous data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q <= '0;
        end else if (rd_addr_i < DEPTH_A) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign armAck_o     = ack_q;
    assign s_ready_o    = busy;
    assign rd_data_o    = rd_data_q;
    assign word_count_o = count_q;
    assign frame_done_o = (state_q == S_DONE);
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_axis_frame_capture.sv
// tb/tb_axis_frame_capture.sv - randomized directed bench for axis_frame_capture with queue-based frame model
module tb_axis_frame_capture;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 784;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              arm = 1'b0;
    logic              arm_ack;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] word_count;
    logic              frame_done;
    logic              overflow;
    logic              timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    int ack_cnt = 0;

    logic [DATA_W-1:0] frame_q [$];
    bit                last_seen;

    axis_frame_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .arm_i       (arm),
        .armAck_o    (arm_ack),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_ready_o   (s_ready),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .word_count_o(word_count),
        .frame_done_o(frame_done),
        .overflow_o  (overflow),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (arm_ack === 1'b1) ack_cnt <= ack_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_count();
        return (frame_q.size() > DEPTH) ? DEPTH : frame_q.size();
    endfunction

    function automatic bit exp_overflow();
        return (frame_q.size() > DEPTH) || (frame_q.size() == DEPTH && !last_seen);
    endfunction

    task automatic do_arm(input string tag);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        frame_q.delete();
        last_seen = 1'b0;
        check({tag, "_armack"}, arm_ack, 1'b1);
        check({tag, "_count_clr"}, word_count, 0);
        check({tag, "_done_clr"}, frame_done, 1'b0);
        check({tag, "_ovf_clr"}, overflow, 1'b0);
        check({tag, "_to_clr"}, timeout, 1'b0);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input bit last, input int gap_max);
        int waited;
        repeat ($urandom_range(0, gap_max)) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waited  = 0;
        while (s_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("handshake_bound", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        frame_q.push_back(d);
        if (last) last_seen = 1'b1;
    endtask

    task automatic check_frame(input string tag, input bit exp_to);
        check({tag, "_count"}, word_count, exp_count());
        check({tag, "_overflow"}, overflow, exp_overflow());
        check({tag, "_done"}, frame_done, last_seen || exp_to);
        check({tag, "_timeout"}, timeout, exp_to);
    endtask

    task automatic readback(input string tag, input int addr);
        rd_addr = ADDR_W'(addr);
        tick();
        check({tag, "_rd"}, rd_data, frame_q[addr]);
    endtask

    initial begin
        int acks_before;

        // Reset with s_valid held high.
        s_valid = 1'b1;
        repeat (3) tick();
        check("rst_ready", s_ready, 1'b0);
        check("rst_ack", arm_ack, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_to", timeout, 1'b0);
        check("rst_count", word_count, 0);
        check("rst_rd", rd_data, 0);
        rst = 1'b1;
        repeat (3) tick();
        check("idle_ready", s_ready, 1'b0);
        check("idle_count", word_count, 0);
        check("idle_done", frame_done, 1'b0);
        s_valid = 1'b0;

        // Nominal full-size frame with s_last on word DEPTH.
        acks_before = ack_cnt;
        do_arm("nom");
        for (int i = 0; i < DEPTH; i++) send_word(DATA_W'(i), i == DEPTH - 1, 0);
        check_frame("nom", 1'b0);
        check("nom_ack_pulses", ack_cnt - acks_before, 1);
        readback("nom_500", 500);
        check("nom_500_lit", rd_data, 500);
        for (int k = 0; k < 3; k++) readback("nom_rand", $urandom_range(0, DEPTH - 1));

        // Short frame with random valid gaps; arm held during capture is ignored.
        do_arm("short");
        for (int i = 0; i < 10; i++) begin
            if (i == 4) arm = 1'b1;
            send_word($urandom, i == 9, 3);
            arm = 1'b0;
        end
        check_frame("short", 1'b0);
        readback("short_9", 9);
        readback("short_0", 0);

        // Overflow: DEPTH words without last, then drain to word 790.
        do_arm("ovf");
        for (int i = 0; i < DEPTH; i++) send_word($urandom, 1'b0, 0);
        check("ovf_mid_ovf", overflow, 1'b1);
        check("ovf_mid_count", word_count, DEPTH);
        check("ovf_mid_done", frame_done, 1'b0);
        check("ovf_mid_ready", s_ready, 1'b1);
        for (int i = DEPTH; i < 790; i++) send_word($urandom, i == 789, 1);
        check_frame("ovf", 1'b0);
        readback("ovf_783", 783);
        readback("ovf_0", 0);

        // Reset mid-frame, then re-arm with a short frame.
        do_arm("mid");
        for (int i = 0; i < 100; i++) send_word($urandom, 1'b0, 0);
        rst = 1'b0;
        #2;
        check("midrst_done", frame_done, 1'b0);
        check("midrst_count", word_count, 0);
        check("midrst_ready", s_ready, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_arm("rearm");
        for (int i = 0; i < 5; i++) send_word($urandom, i == 4, 2);
        check_frame("rearm", 1'b0);
        readback("rearm_4", 4);

`ifdef CAPTURE_TIMEOUT_EN
        // Idle timeout aborts the capture with a partial count.
        do_arm("to");
        for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 0);
        repeat (TIMEOUT - 1) tick();
        check("to_early_done", frame_done, 1'b0);
        tick();
        check_frame("to", 1'b1);
        readback("to_2", 2);
        do_arm("to_clear");
        send_word($urandom, 1'b1, 0);
        check_frame("to_clear", 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_capture.md
Name: axis_frame_capture

Overview:
- Downstream sink for the AXI-Stream wait stage: captures one frame (e.g. a 784-pixel MNIST image) into an internal buffer.
- The captured frame is exposed through a synchronous random-access read port for the CNN engine.
- Software or the controller arms the block, one frame is captured, and `frame_done` is raised until the next arm.

Parameters:
- DATA_W, 32, stream and buffer word width.
- DEPTH, 784, buffer capacity in words; DEPTH ≥ 2.
- ADDR_W, 10, address/count width; 2^ADDR_W ≥ DEPTH+1.
- TIMEOUT, 1024, idle-cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  start request, level; sampled in IDLE/DONE.
- armAck  out  1  one-cycle pulse on entry to CAPTURE.
- s_valid  in  1  upstream data valid.
- s_data  in  DATA_W  upstream data.
- s_last  in  1  last word of frame.
- s_ready  out  1  accept strobe.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  DATA_W  buffer read data, 1-cycle latency.
- word_count  out  ADDR_W  words stored in the current/last frame.
- frame_done  out  1  frame complete, level.
- overflow  out  1  sticky: frame exceeded DEPTH.
- timeout  out  1  sticky: capture aborted on idle (only when the feature is compiled in, else tied 0).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - s_ready, armAck, frame_done, overflow, timeout = 0.
  - word_count = 0; rd_data = 0.
  - Buffer contents are undefined.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: s_ready=0. arm=1 → CAPTURE next cycle; word_count, overflow, timeout cleared.
- CAPTURE: s_ready=1.
  - Transfer = s_valid & s_ready; writes s_data to buffer[word_count] and increments word_count.
  - Transfer with s_last=1 → DONE.
  - Transfer (no s_last) that makes word_count==DEPTH → DRAIN, overflow=1.
  - Transfer with s_last=1 on word DEPTH → DONE, overflow stays 0.
- DRAIN: s_ready=1.
  - Words are accepted and discarded; word_count holds DEPTH.
  - Transfer with s_last=1 → DONE.
- DONE: frame_done=1, s_ready=0.
  - arm=1 → CAPTURE: same-cycle clear of frame_done/overflow/timeout/word_count, armAck pulses.
- armAck: high exactly one cycle, in the first cycle of CAPTURE.
- arm while in CAPTURE/DRAIN is ignored.
- Read port:
  - rd_data <= buffer[rd_addr] every cycle, independent of state.
  - Reads of addresses ≥ word_count return stale data.
  - Same-address read during a write returns the old value.
- Back-pressure: s_ready depends only on state, never combinationally on s_valid.
- Empty frame impossible: the minimum frame is one word with s_last.
- Reset mid-capture: immediate return to IDLE, partial frame discarded, no frame_done.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - An idle counter increments each CAPTURE/DRAIN cycle without a transfer and resets on a transfer.
  - Reaching TIMEOUT → DONE with timeout=1 and frame_done=1; word_count keeps the partial count.
- Undefined: no counter; the timeout port is driven 0; CAPTURE/DRAIN wait indefinitely.

Test Plan:
- Reset then idle: rst low 3 cycles → all outputs 0.
  - With s_valid=1 held, s_ready stays 0 and no write occurs.
- Nominal frame: arm, stream 784 words 0..783 with s_last on the last → armAck one pulse, frame_done=1, word_count=784, overflow=0.
  - rd_addr=500 returns 500 one cycle later.
- Short frame with gaps: 10 words with random s_valid gaps, s_last on word 10 → word_count=10, frame_done=1.
  - rd_addr=9 returns word 10.
- Overflow: 790 words, s_last on 790 → DRAIN after 784, overflow=1, word_count=784.
  - buffer[783] = word 784; frame_done after word 790.
- Reset mid-frame then re-arm: rst low after 100 words → frame_done=0, word_count=0.
  - Re-arm with a 5-word frame → word_count=5.
- CAPTURE_TIMEOUT_EN with TIMEOUT=16: 3 words then s_valid low 16 cycles → timeout=1, frame_done=1, word_count=3.
  - Next arm clears timeout.
